// File: rtl/exc_sched_pkg.sv
// exc_sched_pkg: shared types, state encodings and vector defaults for the exception sequencer.
package exc_sched_pkg;
  localparam int BEV = 22;
  localparam logic [31:0] EXC_VEC_BEV = 32'hBFC00380;
  localparam logic [31:0] EXC_VEC_NORM = 32'h80000180;
  typedef enum logic [4:0] {
    EXC_INTR = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYSC = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12,
    EXC_ERET = 5'd31
  } exc_t;
  typedef enum logic [2:0] {
    EXS_IDLE     = 3'd0,
    EXS_WAIT_BUS = 3'd1,
    EXS_COMMIT   = 3'd2,
    EXS_FLUSH    = 3'd3,
    EXS_REDIRECT = 3'd4
  } exs_t;
endpackage

// File: rtl/exc_sched_if.sv
// exc_sched_if: MEM/cp0/fetch-side signal bundle of the exception sequencer.
interface exc_sched_if;
  import exc_sched_pkg::*;
  logic mem_valid;
  logic [31:0] mem_pc;
  logic mem_exc_flag;
  exc_t mem_exc_type;
  logic mem_inslot;
  logic [31:0] mem_baddr;
  logic exc_intr;
  logic [31:0] status;
  logic [31:0] epc;
  logic dbus_busy;
  logic if_ready;
  logic cp0_exc_flag;
  exc_t cp0_exc_type;
  logic [31:0] cp0_pc;
  logic cp0_inslot;
  logic [31:0] cp0_baddr;
  logic flush;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic busy;
  modport slave(
    input mem_valid, mem_pc, mem_exc_flag, mem_exc_type, mem_inslot, mem_baddr,
    input exc_intr, status, epc, dbus_busy, if_ready,
    output cp0_exc_flag, cp0_exc_type, cp0_pc, cp0_inslot, cp0_baddr,
    output flush, redirect_valid, redirect_pc, busy
  );
  modport master(
    output mem_valid, mem_pc, mem_exc_flag, mem_exc_type, mem_inslot, mem_baddr,
    output exc_intr, status, epc, dbus_busy, if_ready,
    input cp0_exc_flag, cp0_exc_type, cp0_pc, cp0_inslot, cp0_baddr,
    input flush, redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/exc_vec_sel.sv
// exc_vec_sel: redirect target select -- EPC for ERET, otherwise the BEV-dependent exception vector.
module exc_vec_sel
  import exc_sched_pkg::*;
#(
  parameter logic [31:0] VEC_BEV = EXC_VEC_BEV,
  parameter logic [31:0] VEC_NORM = EXC_VEC_NORM
) (
  input  exc_t        typ,
  input  logic        bev,
  input  logic [31:0] epc,
  output logic [31:0] vec
);
  always_comb vec = (typ == EXC_ERET) ? epc : (bev ? VEC_BEV : VEC_NORM);
endmodule

// File: rtl/exc_sched.sv
// exc_sched: exception commit sequencer (capture at MEM, drain bus, commit to cp0, flush, redirect fetch).
// Define EXC_SCHED_BUS_WAIT_EN to hold the commit while dbus_busy is high.
module exc_sched
  import exc_sched_pkg::*;
#(
  parameter int FLUSH_CYC = 2,
  parameter logic [31:0] VEC_BEV = EXC_VEC_BEV,
  parameter logic [31:0] VEC_NORM = EXC_VEC_NORM
) (
  input logic clk,
  input logic rst,
  exc_sched_if.slave bus
);
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYC - 1);
  exs_t state;
  logic [3:0] cnt;
  exc_t cap_typ;
  logic [31:0] cap_pc;
  logic cap_inslot;
  logic [31:0] cap_baddr;
  logic [31:0] redirect_pc;
  logic [31:0] vec;
  logic take;
  assign take = bus.mem_valid & (bus.exc_intr | bus.mem_exc_flag);
  exc_vec_sel #(.VEC_BEV(VEC_BEV), .VEC_NORM(VEC_NORM)) u_vec_sel (
    .typ(cap_typ),
    .bev(bus.status[BEV]),
    .epc(bus.epc),
    .vec(vec)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= EXS_IDLE;
      cnt <= '0;
      cap_typ <= EXC_INTR;
      cap_pc <= '0;
      cap_inslot <= 1'b0;
      cap_baddr <= '0;
      redirect_pc <= '0;
    end else begin
      case (state)
        EXS_IDLE:
          if (take) begin
            cap_typ <= bus.exc_intr ? EXC_INTR : bus.mem_exc_type;
            cap_pc <= bus.mem_pc;
            cap_inslot <= bus.mem_inslot;
            cap_baddr <= bus.mem_baddr;
`ifdef EXC_SCHED_BUS_WAIT_EN
            state <= bus.dbus_busy ? EXS_WAIT_BUS : EXS_COMMIT;
`else
            state <= EXS_COMMIT;
`endif
          end
`ifdef EXC_SCHED_BUS_WAIT_EN
        EXS_WAIT_BUS: if (!bus.dbus_busy) state <= EXS_COMMIT;
`endif
        EXS_COMMIT: begin
          redirect_pc <= vec;
          cnt <= CNT_INIT;
          state <= EXS_FLUSH;
        end
        EXS_FLUSH:
          if (cnt == 4'd0) state <= EXS_REDIRECT;
          else cnt <= cnt - 4'd1;
        EXS_REDIRECT: if (bus.if_ready) state <= EXS_IDLE;
        default: state <= EXS_IDLE;
      endcase
    end
  // cp0 fields hold the capture; only the strobe is qualified by COMMIT
  assign bus.cp0_exc_flag = state == EXS_COMMIT;
  assign bus.cp0_exc_type = cap_typ;
  assign bus.cp0_pc = cap_pc;
  assign bus.cp0_inslot = cap_inslot;
  assign bus.cp0_baddr = cap_baddr;
  assign bus.flush = state != EXS_IDLE;
  assign bus.busy = state != EXS_IDLE;
  assign bus.redirect_valid = state == EXS_REDIRECT;
  assign bus.redirect_pc = redirect_pc;
endmodule
